// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: write-back, HI/LO and MADD/MSUB partial state.
// Optional load/store fields are enabled with the EXMEM_LSU_EN macro.
module ex_mem_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic                  ex_we,
  input  logic [ADDR_W-1:0]     ex_w_addr,
  input  logic [DATA_W-1:0]     ex_w_data,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
  input  logic [CNT_W-1:0]      ex_cnt,
`ifdef EXMEM_LSU_EN
  input  logic [7:0]            ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_store_data,
  output logic [7:0]            mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_store_data,
`endif
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_w_addr,
  output logic [DATA_W-1:0]     mem_w_data,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_valid,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o
);

  localparam int unsigned HILO_W = 2 * DATA_W;

  logic                w_advance;
  logic                w_bubble;

  logic                r_we;
  logic [ADDR_W-1:0]   r_w_addr;
  logic [DATA_W-1:0]   r_w_data;
  logic                r_whilo;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_valid;
  logic [HILO_W-1:0]   r_hilo_temp;
  logic [CNT_W-1:0]    r_cnt;

  // stall_ex=0 with stall_mem=1 never advances: it falls through to hold
  assign w_advance = !stall_ex && !stall_mem;
  assign w_bubble  =  stall_ex && !stall_mem;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_we        <= 1'b0;
      r_w_addr    <= '0;
      r_w_data    <= '0;
      r_whilo     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_valid     <= 1'b0;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else if (w_bubble) begin
      // NOP downstream; execute's partial MADD/MSUB state loops back
      r_we        <= 1'b0;
      r_w_addr    <= '0;
      r_w_data    <= '0;
      r_whilo     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_valid     <= 1'b0;
      r_hilo_temp <= ex_hilo_temp;
      r_cnt       <= ex_cnt;
    end else if (w_advance) begin
      r_we        <= ex_we;
      r_w_addr    <= ex_w_addr;
      r_w_data    <= ex_w_data;
      r_whilo     <= ex_whilo;
      r_hi        <= ex_hi;
      r_lo        <= ex_lo;
      r_valid     <= 1'b1;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end
  end

`ifdef EXMEM_LSU_EN
  logic [7:0]          r_aluop;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_store_data;

  always_ff @(posedge clk) begin
    if (rst || flush || w_bubble) begin
      r_aluop      <= '0;
      r_mem_addr   <= '0;
      r_store_data <= '0;
    end else if (w_advance) begin
      r_aluop      <= ex_aluop;
      r_mem_addr   <= ex_mem_addr;
      r_store_data <= ex_store_data;
    end
  end

  assign mem_aluop      = r_aluop;
  assign mem_mem_addr   = r_mem_addr;
  assign mem_store_data = r_store_data;
`endif

  assign mem_we      = r_we;
  assign mem_w_addr  = r_w_addr;
  assign mem_w_data  = r_w_data;
  assign mem_whilo   = r_whilo;
  assign mem_hi      = r_hi;
  assign mem_lo      = r_lo;
  assign mem_valid   = r_valid;
  assign hilo_temp_o = r_hilo_temp;
  assign cnt_o       = r_cnt;

  // The stall controller must never stall memory while execute advances
  a_no_mem_only_stall: assert property (@(posedge clk) disable iff (rst)
    !(!stall_ex && stall_mem));

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: reference model feeds a scoreboard queue,
// popped and compared one cycle later against the registered outputs.
module tb_ex_mem_reg;

  typedef struct packed {
    logic        we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
    logic [63:0] hilo_temp;
    logic [1:0]  cnt;
`ifdef EXMEM_LSU_EN
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
`endif
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall_ex, stall_mem, flush;
  logic        ex_we, ex_whilo;
  logic [4:0]  ex_w_addr;
  logic [31:0] ex_w_data, ex_hi, ex_lo;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;
  logic        mem_we, mem_whilo, mem_valid;
  logic [4:0]  mem_w_addr;
  logic [31:0] mem_w_data, mem_hi, mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
`ifdef EXMEM_LSU_EN
  logic [7:0]  ex_aluop, mem_aluop;
  logic [31:0] ex_mem_addr, ex_store_data, mem_mem_addr, mem_store_data;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t model;
  exp_t sb_q[$];

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_we(ex_we), .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
`ifdef EXMEM_LSU_EN
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
`endif
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference behaviour: rst > flush > bubble > advance > hold
  function automatic exp_t next_model(input exp_t cur);
    exp_t n;
    n = cur;
    if (rst || flush) begin
      n = '0;
    end else if (stall_ex && !stall_mem) begin
      n = '0;
      n.hilo_temp = ex_hilo_temp;
      n.cnt       = ex_cnt;
    end else if (!stall_ex && !stall_mem) begin
      n.we = ex_we; n.w_addr = ex_w_addr; n.w_data = ex_w_data;
      n.whilo = ex_whilo; n.hi = ex_hi; n.lo = ex_lo; n.valid = 1'b1;
      n.hilo_temp = '0; n.cnt = '0;
`ifdef EXMEM_LSU_EN
      n.aluop = ex_aluop; n.mem_addr = ex_mem_addr; n.store_data = ex_store_data;
`endif
    end
    return n;
  endfunction

  // One clock: push expectation, clock the DUT, pop and compare off the edge
  task automatic step(input string tag);
    exp_t e;
    model = next_model(model);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".we"},        64'(mem_we),      64'(e.we));
    check({tag, ".w_addr"},    64'(mem_w_addr),  64'(e.w_addr));
    check({tag, ".w_data"},    64'(mem_w_data),  64'(e.w_data));
    check({tag, ".whilo"},     64'(mem_whilo),   64'(e.whilo));
    check({tag, ".hi"},        64'(mem_hi),      64'(e.hi));
    check({tag, ".lo"},        64'(mem_lo),      64'(e.lo));
    check({tag, ".valid"},     64'(mem_valid),   64'(e.valid));
    check({tag, ".hilo_temp"}, hilo_temp_o,      e.hilo_temp);
    check({tag, ".cnt"},       64'(cnt_o),       64'(e.cnt));
`ifdef EXMEM_LSU_EN
    check({tag, ".aluop"},      64'(mem_aluop),      64'(e.aluop));
    check({tag, ".mem_addr"},   64'(mem_mem_addr),   64'(e.mem_addr));
    check({tag, ".store_data"}, 64'(mem_store_data), 64'(e.store_data));
`endif
  endtask

  task automatic drive_ex(input logic we, input logic [4:0] a, input logic [31:0] d,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [63:0] tmp, input logic [1:0] cnt);
    ex_we = we; ex_w_addr = a; ex_w_data = d; ex_whilo = whilo;
    ex_hi = hi; ex_lo = lo; ex_hilo_temp = tmp; ex_cnt = cnt;
`ifdef EXMEM_LSU_EN
    ex_aluop = d[7:0] ^ 8'h5A; ex_mem_addr = d ^ 32'h1000_0000; ex_store_data = ~d;
`endif
  endtask

  initial begin
    model = '1;
    rst = 1'b1; flush = 1'b1; stall_ex = 1'b0; stall_mem = 1'b0;
    drive_ex(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0,
             64'hFFFF_0000_FFFF_0000, 2'd3);

    // Reset with nonzero inputs, two cycles
    step("reset0");
    check("reset0.valid_const", 64'(mem_valid), 64'd0);
    check("reset0.data_const", 64'(mem_w_data), 64'd0);
    step("reset1");
    rst = 1'b0; flush = 1'b0;

    // Advance
    drive_ex(1'b1, 5'd3, 32'h0000_00FF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);
    step("advance");
    check("advance.data_const", 64'(mem_w_data), 64'h0000_00FF);
    check("advance.valid_const", 64'(mem_valid), 64'd1);

    // Bubble with partial product captured
    stall_ex = 1'b1; stall_mem = 1'b0;
    drive_ex(1'b1, 5'd7, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 64'h1_0000_0002, 2'd1);
    step("bubble");
    check("bubble.temp_const", hilo_temp_o, 64'h1_0000_0002);
    check("bubble.cnt_const", 64'(cnt_o), 64'd1);
    check("bubble.we_const", 64'(mem_we), 64'd0);

    // MADD completion
    stall_ex = 1'b0;
    drive_ex(1'b0, 5'd0, 32'h0, 1'b1, 32'h1, 32'h5, 64'h1_0000_0002, 2'd1);
    step("madd_done");
    check("madd_done.lo_const", 64'(mem_lo), 64'h5);
    check("madd_done.cnt_const", 64'(cnt_o), 64'd0);

    // Hold for three cycles while inputs change
    drive_ex(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);
    step("load");
    stall_ex = 1'b1; stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
               {$urandom, $urandom}, 2'($urandom));
      step("hold");
      check("hold.data_const", 64'(mem_w_data), 64'hDEAD_BEEF);
    end

    // Flush in the middle of a multi-cycle sequence
    stall_mem = 1'b0;
    drive_ex(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 64'hABCD_0000_0000_1234, 2'd1);
    step("mid_seq");
    flush = 1'b1;
    drive_ex(1'b1, 5'd4, 32'h4444, 1'b1, 32'h44, 32'h55, 64'h77, 2'd2);
    step("flush");
    check("flush.cnt_const", 64'(cnt_o), 64'd0);
    check("flush.temp_const", hilo_temp_o, 64'd0);
    flush = 1'b0;

    // Randomised legal traffic, including occasional flush and reset
    for (int i = 0; i < 300; i++) begin
      stall_ex  = 1'($urandom_range(0, 2) == 0);
      stall_mem = stall_ex ? 1'($urandom) : 1'b0;
      flush     = 1'($urandom_range(0, 15) == 0);
      rst       = 1'($urandom_range(0, 40) == 0);
      drive_ex(1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
               {$urandom, $urandom}, 2'($urandom));
      step("random");
    end

    if (sb_q.size() != 0) check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage integer pipeline.
- Captures the execute-stage result (register write-back, HI/LO write-back) on each clock.
- Honours per-stage stall and global flush.
- Holds the 64-bit partial product and the 2-bit cycle count for two-cycle multiply-accumulate (MADD/MSUB) and feeds them back to the execute stage while that stage is stalled.

Parameters:
- DATA_W, 32, register/HI/LO data width
- ADDR_W, 5, register-file address width
- CNT_W, 2, multi-cycle step counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall_ex  in  1  execute stage stalled this cycle
- stall_mem  in  1  memory stage stalled this cycle
- flush  in  1  exception/branch flush, clears register contents
- ex_we  in  1  execute result writes register file
- ex_w_addr  in  ADDR_W  destination register
- ex_w_data  in  DATA_W  execute result
- ex_whilo  in  1  execute result writes HI/LO
- ex_hi  in  DATA_W  HI value
- ex_lo  in  DATA_W  LO value
- ex_hilo_temp  in  2*DATA_W  partial MADD/MSUB product from execute
- ex_cnt  in  CNT_W  execute multi-cycle step number
- mem_we  out  1  registered ex_we
- mem_w_addr  out  ADDR_W  registered ex_w_addr
- mem_w_data  out  DATA_W  registered ex_w_data
- mem_whilo  out  1  registered ex_whilo
- mem_hi  out  DATA_W  registered ex_hi
- mem_lo  out  DATA_W  registered ex_lo
- mem_valid  out  1  1 = real instruction, 0 = bubble/reset/flush
- hilo_temp_o  out  2*DATA_W  partial product returned to execute
- cnt_o  out  CNT_W  step count returned to execute

Behaviour:
- All state updates on rising clk. rst and flush are both synchronous, with rst taking priority over everything.
- Reset and flush: clear every output to 0, including hilo_temp_o, cnt_o and mem_valid.
- Mode is chosen once per cycle, in priority order rst > flush > bubble > advance > hold:
  - ADVANCE (stall_ex=0): load every ex_* field into its mem_* output; mem_valid<=1; hilo_temp_o<=0; cnt_o<=0.
  - BUBBLE (stall_ex=1, stall_mem=0): the downstream stage moves on, so a NOP is inserted. Clear mem_we, mem_w_addr, mem_w_data, mem_whilo, mem_hi, mem_lo and mem_valid to 0. Capture hilo_temp_o<=ex_hilo_temp and cnt_o<=ex_cnt, so execute sees its own partial state next cycle.
  - HOLD (stall_ex=1, stall_mem=1): every output keeps its value, including hilo_temp_o and cnt_o.
- The combination stall_ex=0, stall_mem=1 is illegal; the stall controller never produces it. Treat it as HOLD; a simulation assertion flags it.
- Latency: 1 cycle from ex_* to mem_* in ADVANCE. Outputs come directly from flops, with no combinational path from input to output.
- Multi-cycle sequence: execute stalls, giving BUBBLE at cnt 0 with 0->1 captured. The next cycle execute releases the stall, giving ADVANCE, which writes mem_hi/mem_lo and resets cnt_o to 0.
- A flush or rst in the middle of a sequence discards hilo_temp_o and cnt_o.
- Widths are fixed by the parameters; no arithmetic is done in this block.

Optional Feature:
- Macro: EXMEM_LSU_EN.
- When defined, adds these ports:
  - ex_aluop  in  8  operation code
  - ex_mem_addr  in  DATA_W  effective address
  - ex_store_data  in  DATA_W  store data
  - mem_aluop, mem_mem_addr, mem_store_data  out, same widths as their inputs
- These fields follow the same ADVANCE/BUBBLE/HOLD/flush/reset rules as mem_w_data: cleared to 0 on bubble, flush and reset.
- When not defined, the ports do not exist and the block carries only write-back and HI/LO fields.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with all inputs driven nonzero -> every output is 0 after the first edge, and mem_valid=0.
2. Advance: ex_we=1, ex_w_addr=5'd3, ex_w_data=32'h0000_00FF, stalls=0 -> next cycle mem_we=1, mem_w_addr=3, mem_w_data=32'hFF, mem_valid=1, cnt_o=0.
3. Bubble: stall_ex=1, stall_mem=0, ex_hilo_temp=64'h1_0000_0002, ex_cnt=1 -> mem_we=0, mem_valid=0, hilo_temp_o=64'h1_0000_0002, cnt_o=1.
4. MADD completion: after scenario 3, release stall_ex with ex_whilo=1, ex_hi=32'h1, ex_lo=32'h5 -> mem_whilo=1, mem_hi=1, mem_lo=5, hilo_temp_o=0, cnt_o=0.
5. Hold: load data 32'hDEAD_BEEF, then stall_ex=stall_mem=1 for 3 cycles while inputs change -> outputs stay at 32'hDEAD_BEEF.
6. Flush priority: flush=1 together with stall_ex=1, stall_mem=0 and cnt_o=1 -> next cycle all outputs are 0, cnt_o=0, hilo_temp_o=0.
